r_type_program_loader: RTL
==========================

# r_type_program_loader

Encoder and loader for the R-type instruction stream. It is the inverse of the control unit's opcode/funct3/funct7 decode. It accepts ALU operation requests over a valid/ready handshake and encodes each into a 32-bit R-type instruction word. Words pass through a small FIFO and are written sequentially into instruction memory for the IFU to fetch.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory byte-address width
- FIFO_DEPTH, 4, encoded-word buffer entries (power of 2, ≥2)
- MAX_WORDS, 256, maximum words accepted per load session

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clock  in  1  single clock
  - reset_n  in  1  asynchronous, active-low reset
- Session control:
  - start  in  1  begin a session at base_addr (sampled in IDLE/DONE only)
  - base_addr  in  ADDR_W  first write address; bits [1:0] ignored, forced 0
  - finish  in  1  end the session after the current accept
- Request handshake:
  - in_valid  in  1  request valid
  - in_ready  out  1  request may be accepted this cycle
  - alu_op  in  4  ALU control code
  - rd, rs1, rs2  in  5 each  register indices
- Memory write port:
  - mem_we  out  1  write request
  - mem_ready  in  1  memory accepts write this cycle
  - mem_addr  out  ADDR_W  byte address of write
  - mem_wdata  out  32  instruction word
- Status:
  - done  out  1  high in DONE
  - words_written  out  $clog2(MAX_WORDS+1)  words written this session
  - illegal_seen  out  1  sticky: illegal alu_op consumed this session

## Operation
- Encoding: word = {funct7, rs2, rs1, funct3, rd, 7'b0110011}. The alu_op mapping is:
  - 0010 ADD: f3=0, f7=0
  - 1001 HCF: f3=0, f7=0000001
  - 0001 OR: f3=6
  - 0000 AND: f3=7
  - 0011 SLL: f3=1
  - 0101 SRL: f3=5
  - 0110 MUL: f3=2
  - 0111 XOR: f3=4
  - f7=0 for every op except HCF.
- Illegal ops: any other alu_op is illegal. It is consumed by the handshake but not pushed or written, and it sets illegal_seen.
- IDLE: in_ready=0. start → LOAD. On that transition: write address ← {base_addr[ADDR_W-1:2],2'b00}, accept count ← 0, words_written ← 0, illegal_seen ← 0.
- LOAD: in_ready = !fifo_full && accept_count < MAX_WORDS.
  - Accept = in_valid && in_ready. Every accept (legal or illegal) increments accept_count.
  - Transition to DRAIN when finish=1, or when the accept that brings accept_count to MAX_WORDS occurs.
- DRAIN: in_ready=0. Transition to DONE when the FIFO is empty and no write is pending.
- DONE: done=1, in_ready=0. start → LOAD (new session; same initialisation as from IDLE).
- start is ignored in LOAD and DRAIN. finish is ignored outside LOAD.
- Write side (LOAD and DRAIN):
  - mem_we = !fifo_empty. mem_wdata/mem_addr = FIFO head and current address.
  - A write completes when mem_we && mem_ready. On completion: pop, address += 4 (wraps modulo 2^ADDR_W), words_written += 1.
  - mem_we, mem_addr and mem_wdata hold stable while mem_ready=0.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - done=0, words_written=0, illegal_seen=0
  - FIFO empty
- Latency: a legal accept in cycle N is pushed at the edge ending N; the earliest mem_we for it is cycle N+1.
- Back-to-back: with mem_ready=1 continuously, sustained throughput is one word per cycle.
- FIFO full: in_ready=0 even if a pop happens that cycle. in_ready is a registered-state function only, with no mem_ready→in_ready combinational path.
- Simultaneous in_valid and finish in LOAD: the request is accepted if in_ready=1, then the block enters DRAIN.
- finish with in_ready=0: the block enters DRAIN; the pending request is not accepted.
- DRAIN→DONE: DONE is entered the cycle after the last write completes. If the FIFO is already empty on entering DRAIN, DONE follows on the next cycle.
- Address wrap: 0x3FC + 4 → 0x000 (ADDR_W=10); no flag is raised.
- Reset mid-session: the FIFO is flushed, buffered words are lost, and mem_we drops immediately (asynchronously).

## Test plan
- ADD: start with base_addr=0x040, accept alu_op=0010, rd=3, rs1=1, rs2=2, then finish → one write, mem_addr=0x040, mem_wdata=0x002081B3; DONE, words_written=1.
- HCF then OR: HCF rd=5, rs1=6, rs2=7 → 0x027302B3 at 0x040; OR rd=1, rs1=2, rs2=3 → 0x003160B3 at 0x044.
- Illegal op: alu_op=1111 accepted → no write, illegal_seen=1, words_written=0. The next legal op is written at base_addr.
- Backpressure: hold mem_ready=0 and offer 6 requests → exactly 4 accepted, then in_ready=0, with mem_we/mem_addr/mem_wdata stable. Release → 4 writes at +0, +4, +8, +C, then the remaining 2 are accepted.
- Wrap and limit: MAX_WORDS=3, base_addr=0x3F8, 3 ADDs → writes at 0x3F8, 0x3FC, 0x000; DRAIN entered without finish; words_written=3.
- Reset mid-DRAIN: pull reset_n low with 2 words buffered → mem_we=0 immediately. After release: IDLE, all outputs at reset values, no further writes.

Source files
------------

// File: rtl/r_type_program_loader.sv
// r_type_program_loader
// Turns ALU operation requests into 32-bit R-type instruction words, queues
// them in a small FIFO and writes them to consecutive instruction-memory
// addresses starting at a session base address.
module r_type_program_loader #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WORDS  = 256
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [ADDR_W-1:0]              base_addr,
    input  logic                           finish,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [3:0]                     alu_op,
    input  logic [4:0]                     rd,
    input  logic [4:0]                     rs1,
    input  logic [4:0]                     rs2,
    output logic                           mem_we,
    input  logic                           mem_ready,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic                           done,
    output logic [$clog2(MAX_WORDS+1)-1:0] words_written,
    output logic                           illegal_seen
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [6:0]        OPCODE_R   = 7'b0110011;
    localparam logic [CNT_W-1:0]  ACCEPT_MAX = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0]  ACCEPT_END = CNT_W'(MAX_WORDS - 1);
    localparam logic [PTR_W:0]    COUNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  accept_count;
    logic [ADDR_W-1:0] write_addr;

    logic [31:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic              op_legal;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       encoded_word;

    logic              accept;
    logic              push;
    logic              pop;
    logic              last_pop;

    // Map the ALU control code back to its funct3/funct7 pair; unknown codes are illegal.
    always_comb begin
        op_legal = 1'b1;
        funct3   = 3'd0;
        funct7   = 7'd0;
        case (alu_op)
            4'b0010: funct3 = 3'd0;
            4'b1001: funct7 = 7'b0000001;
            4'b0001: funct3 = 3'd6;
            4'b0000: funct3 = 3'd7;
            4'b0011: funct3 = 3'd1;
            4'b0101: funct3 = 3'd5;
            4'b0110: funct3 = 3'd2;
            4'b0111: funct3 = 3'd4;
            default: op_legal = 1'b0;
        endcase
    end

    assign encoded_word = {funct7, rs2, rs1, funct3, rd, OPCODE_R};

    assign fifo_full  = (fifo_count == COUNT_FULL);
    assign fifo_empty = (fifo_count == '0);

    // in_ready depends on registered state only, so a same-cycle pop never frees a slot.
    assign in_ready = (state == ST_LOAD) && !fifo_full && (accept_count < ACCEPT_MAX);
    assign accept   = in_valid && in_ready;
    assign push     = accept && op_legal;
    assign pop      = mem_we && mem_ready;
    assign last_pop = pop && (fifo_count == COUNT_ONE);

    assign mem_we    = !fifo_empty;
    assign mem_addr  = write_addr;
    assign mem_wdata = fifo_empty ? 32'd0 : fifo_mem[rd_ptr];

    // Word storage needs no reset; an empty FIFO masks its contents on mem_wdata.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= encoded_word;
        end
    end

    // FIFO pointers and occupancy; reset empties the FIFO so mem_we drops at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Session FSM plus the address, counters and status flags it owns.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            done          <= 1'b0;
            accept_count  <= '0;
            write_addr    <= '0;
            words_written <= '0;
            illegal_seen  <= 1'b0;
        end else begin
            if (pop) begin
                write_addr    <= write_addr + WORD_STEP;
                words_written <= words_written + 1'b1;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state         <= ST_LOAD;
                        done          <= 1'b0;
                        write_addr    <= base_addr & ALIGN_MASK;
                        accept_count  <= '0;
                        words_written <= '0;
                        illegal_seen  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        accept_count <= accept_count + 1'b1;
                        if (!op_legal) begin
                            illegal_seen <= 1'b1;
                        end
                    end
                    if (finish || (accept && (accept_count == ACCEPT_END))) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty || last_pop) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
